// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Pure declarations; no timing or flow-control behaviour of its own.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_TO_W        = 8;
  localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter: +1 per cycle of inc, holds at all-ones, never wraps.
// Count visible one cycle after the inc cycle; no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges hazard, branch and SRAM handshake into pipeline controls.
// Controls are combinational (same cycle) from state and inputs; the SRAM handshake freezes the pipe.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int TO_W        = DEF_TO_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             freeze_front,
  output logic             freeze_back,
  output logic             bubble_id_exe,
  output logic             bubble_mem_wb,
  output logic             flush_if_id,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic mem_acc;
  logic mem_freeze;
  logic req_c, ff_c, fb_c, bid_c, bmw_c, flush_c, to_c;

  always_comb begin
    mem_acc    = mem_r_en | mem_w_en;
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    mem_freeze = 1'b0;
    req_c      = 1'b0;
    to_c       = 1'b0;

    case (state_q)
      RUN: begin
        // SRAM latency is at least one cycle, so mem_ready is not looked at here.
        if (mem_acc) begin
          mem_freeze = 1'b1;
          req_c      = 1'b1;
          state_d    = MEM_WAIT;
          to_cnt_d   = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        req_c = 1'b1;
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          mem_freeze = 1'b1;
          if (to_cnt_q == TO_W'(MEM_TIMEOUT)) begin
            state_d = ERROR;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      ERROR: begin
        mem_freeze = 1'b1;
        to_c       = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    ff_c    = mem_freeze;
    fb_c    = mem_freeze;
    bmw_c   = mem_freeze;
    bid_c   = 1'b0;
    flush_c = 1'b0;
    // A memory freeze holds ID/EXE, so hazard and branch wait until the pipe moves.
    if (!mem_freeze) begin
      if (branch_taken) begin
        flush_c = 1'b1;
        bid_c   = 1'b1;
      end else if (hazard_detected) begin
        ff_c  = 1'b1;
        bid_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Outputs are forced low for the whole reset assertion, not just after an edge.
  assign mem_req       = rst_n & req_c;
  assign freeze_front  = rst_n & ff_c;
  assign freeze_back   = rst_n & fb_c;
  assign bubble_id_exe = rst_n & bid_c;
  assign bubble_mem_wb = rst_n & bmw_c;
  assign flush_if_id   = rst_n & flush_c;
  assign mem_timeout   = rst_n & to_c;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze_front),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_if_id),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; a second instance with 3-bit counters covers saturation.
module tb_pipeline_stall_controller;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic hazard_detected, branch_taken, mem_r_en, mem_w_en, mem_ready;

  logic        mem_req, freeze_front, freeze_back, bubble_id_exe, bubble_mem_wb, flush_if_id, mem_timeout;
  logic [31:0] stall_count, flush_count;

  logic        s_mem_req, s_ff, s_fb, s_bid, s_bmw, s_flush, s_to;
  logic [2:0]  s_stall_count, s_flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_ready(mem_ready),
    .mem_req(mem_req), .freeze_front(freeze_front), .freeze_back(freeze_back),
    .bubble_id_exe(bubble_id_exe), .bubble_mem_wb(bubble_mem_wb),
    .flush_if_id(flush_if_id), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(255), .TO_W(8), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .freeze_front(s_ff), .freeze_back(s_fb),
    .bubble_id_exe(s_bid), .bubble_mem_wb(s_bmw),
    .flush_if_id(s_flush), .mem_timeout(s_to),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // {mem_req, freeze_front, freeze_back, bubble_id_exe, bubble_mem_wb, flush_if_id, mem_timeout}
  logic [6:0] outs;
  logic [6:0] s_outs;
  assign outs   = {mem_req, freeze_front, freeze_back, bubble_id_exe, bubble_mem_wb, flush_if_id, mem_timeout};
  assign s_outs = {s_mem_req, s_ff, s_fb, s_bid, s_bmw, s_flush, s_to};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic hz, input logic br, input logic rd, input logic wr, input logic rdy);
    hazard_detected = hz;
    branch_taken    = br;
    mem_r_en        = rd;
    mem_w_en        = wr;
    mem_ready       = rdy;
  endtask

  // Drive one cycle's inputs, check the control vector mid-cycle, advance past the next edge.
  task automatic cyc(input string tag, input logic hz, input logic br, input logic rd,
                     input logic wr, input logic rdy, input logic [6:0] exp);
    drive(hz, br, rd, wr, rdy);
    @(negedge clk);
    chk(tag, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] IDLE   = 7'b0000000;
  localparam logic [6:0] HAZ    = 7'b0101000;
  localparam logic [6:0] BRANCH = 7'b0001010;
  localparam logic [6:0] MWAIT  = 7'b1110100;
  localparam logic [6:0] MDONE  = 7'b1000000;
  localparam logic [6:0] MERR   = 7'b0110101;

  initial begin
    // 1: reset hold with every input high
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 1);
    #3;
    chk("rst_outs_t0", 32'(outs), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs_held", 32'(outs), 32'(IDLE));
    chk("rst_outs_sat", 32'(s_outs), 32'(IDLE));
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_state", 32'(u_dut.state_q), 32'(RUN));
    chk("rst_stall_cnt", stall_count, 32'd0);
    chk("rst_flush_cnt", flush_count, 32'd0);
    cyc("idle", 0, 0, 0, 0, 0, IDLE);

    // 2: two hazard cycles
    cyc("haz_c0", 1, 0, 0, 0, 0, HAZ);
    cyc("haz_c1", 1, 0, 0, 0, 0, HAZ);
    chk("haz_stall_cnt", stall_count, 32'd2);
    chk("haz_flush_cnt", flush_count, 32'd0);

    // 3: branch beats hazard
    cyc("br_hz", 1, 1, 0, 0, 0, BRANCH);
    chk("br_flush_cnt", flush_count, 32'd1);
    chk("br_stall_cnt", stall_count, 32'd2);

    // 4: load answered three cycles after the request; branch masked during wait
    cyc("ld_req", 0, 0, 1, 0, 0, MWAIT);
    cyc("ld_w1_br", 0, 1, 1, 0, 0, MWAIT);
    cyc("ld_w2_br", 0, 1, 1, 0, 0, MWAIT);
    cyc("ld_ready", 0, 0, 1, 0, 1, MDONE);
    cyc("ld_after", 0, 0, 0, 0, 0, IDLE);
    chk("ld_stall_cnt", stall_count, 32'd5);
    chk("ld_flush_cnt", flush_count, 32'd1);

    // 5: back-to-back load then store, each ready after one cycle
    cyc("b2b_ld_req", 0, 0, 1, 0, 0, MWAIT);
    chk("b2b_st1", 32'(u_dut.state_q), 32'(MEM_WAIT));
    cyc("b2b_ld_rdy", 0, 0, 1, 0, 1, MDONE);
    chk("b2b_st2", 32'(u_dut.state_q), 32'(RUN));
    cyc("b2b_st_req", 0, 0, 0, 1, 0, MWAIT);
    chk("b2b_st3", 32'(u_dut.state_q), 32'(MEM_WAIT));
    cyc("b2b_st_rdy", 0, 0, 0, 1, 1, MDONE);
    cyc("b2b_after", 0, 0, 0, 0, 0, IDLE);
    chk("b2b_stall_cnt", stall_count, 32'd7);

    // 6: SRAM never answers, timeout of 4
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("to_wait%0d", i), 0, 0, 1, 0, 0, MWAIT);
    end
    chk("to_state", 32'(u_dut.state_q), 32'(ERROR));
    cyc("to_err0", 0, 0, 1, 0, 0, MERR);
    cyc("to_err_rdy_br", 1, 1, 1, 0, 1, MERR);
    chk("to_stall_cnt", stall_count, 32'd14);
    chk("to_flush_cnt", flush_count, 32'd1);

    // Reset pulse with a load still presented: mem_req must drop at once
    drive(0, 0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst2_outs", 32'(outs), 32'(IDLE));
    chk("rst2_sat_req", 32'(s_mem_req), 32'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_state", 32'(u_dut.state_q), 32'(RUN));
    chk("rst2_stall_cnt", stall_count, 32'd0);
    cyc("rst2_idle", 0, 0, 0, 0, 0, IDLE);

    // Saturation of a 3-bit stall counter under continuous hazard
    for (int i = 0; i < 7; i++) begin
      cyc($sformatf("sat_haz%0d", i), 1, 0, 0, 0, 0, HAZ);
    end
    chk("sat_at7", 32'(s_stall_count), 32'd7);
    cyc("sat_haz7", 1, 0, 0, 0, 0, HAZ);
    cyc("sat_haz8", 1, 0, 0, 0, 0, HAZ);
    chk("sat_hold", 32'(s_stall_count), 32'd7);
    chk("sat_wide_cnt", stall_count, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
